// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// access-width mask and request legality helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD   = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_ST   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } lsu_state_t;

    // Mask covering the low N bytes of the 8-byte window; funct3[1:0] encodes N.
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00ff;
            2'd1:    m = 64'h0000_0000_0000_ffff;
            2'd2:    m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

    function automatic logic bad_funct3(input logic is_store, input logic [2:0] f3);
        return is_store ? f3[2] : (f3 == 3'd7);
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane logic: extract and sign/zero-extend load data,
// and merge new store bytes into the old 8-byte window.
module load_store_unit_byte_lane
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] old_data,
    input  logic [63:0] new_data,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    logic [63:0] mask;

    assign mask = size_mask(funct3[1:0]);

    always_comb begin
        load_data = old_data;
        case (funct3)
            F3_B:    load_data = {{56{old_data[7]}},  old_data[7:0]};
            F3_H:    load_data = {{48{old_data[15]}}, old_data[15:0]};
            F3_W:    load_data = {{32{old_data[31]}}, old_data[31:0]};
            F3_D:    load_data = old_data;
            F3_BU:   load_data = {56'd0, old_data[7:0]};
            F3_HU:   load_data = {48'd0, old_data[15:0]};
            F3_WU:   load_data = {32'd0, old_data[31:0]};
            default: load_data = old_data;
        endcase
    end

    assign store_data = (old_data & ~mask) | (new_data & mask);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access sequencer: extended loads, full-width stores and
// read-modify-write for sub-doubleword stores, all outputs registered.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] adr,
    input  logic [63:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [63:0]       rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic [2:0]        dbg_state
);

    // Handshake: req is taken on any rising edge where the unit is idle-like
    // (IDLE, DONE or ERR); it is ignored while busy and never queued.
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(MEM_BYTES - 8);

    lsu_state_t  state, state_n;
    logic [2:0]  funct3_q;
    logic [63:0] wdata_q;
    logic        idle_like;
    logic        accept;
    logic        bad_req;
    logic [63:0] load_ext;
    logic [63:0] merged;

    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign accept    = req && idle_like;
    assign bad_req   = bad_funct3(is_store, funct3) || (adr > LAST_ADR);
    assign dbg_state = state;

    load_store_unit_byte_lane u_lane (
        .funct3     (funct3_q),
        .old_data   (mem_rdata),
        .new_data   (wdata_q),
        .load_data  (load_ext),
        .store_data (merged)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                state_n = S_IDLE;
                if (req) begin
                    if (bad_req)            state_n = S_ERR;
                    else if (!is_store)     state_n = S_LD;
                    else if (funct3 == F3_D) state_n = S_ST;
                    else                    state_n = S_RD;
                end
            end
            S_LD:    state_n = S_DONE;
            S_RD:    state_n = S_WR;
            S_WR:    state_n = S_DONE;
            S_ST:    state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= '0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_n;
            busy      <= (state_n == S_LD) || (state_n == S_RD) ||
                         (state_n == S_WR) || (state_n == S_ST);
            mem_read  <= (state_n == S_LD) || (state_n == S_RD);
            mem_write <= (state_n == S_WR) || (state_n == S_ST);
            done      <= (state_n == S_DONE);
            err       <= (state_n == S_ERR);

            // Errored requests leave the address and data registers untouched.
            if (accept && (state_n != S_ERR)) begin
                funct3_q <= funct3;
                wdata_q  <= wdata;
                mem_adr  <= adr;
            end
            if (accept && (state_n == S_ST))
                mem_wdata <= wdata;
            if (state == S_RD)
                mem_wdata <= merged;
            if (state == S_LD)
                rdata <= load_ext;
        end
    end

endmodule
